// File: rtl/xdma_pkg.sv
// Shared types and widths for the XDMA write-completion interrupt scheduler.
package xdma_pkg;

  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 32;
  localparam int ID_W     = 8;
  localparam int TIMER_W  = 32;
  localparam int TO_CNT_W = 16;
  localparam int STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_POST     = 3'd2,
    ST_IRQ_SET  = 3'd3,
    ST_WAIT_CLR = 3'd4,
    ST_IRQ_DROP = 3'd5
  } state_e;

  // Timeout statistics stick at all-ones rather than wrapping back to zero.
  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int P_REQ_NUM = 4,
  parameter int IDX_W     = $clog2(P_REQ_NUM)
) (
  input  logic [P_REQ_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [P_REQ_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 gnt_valid_o
);

  logic [IDX_W-1:0] k;

  // Scan farthest-first so the candidate closest to ptr_i is written last and wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    k           = '0;
    for (int d = P_REQ_NUM - 1; d >= 0; d--) begin
      k = IDX_W'((32'(ptr_i) + 32'(d)) % P_REQ_NUM);
      if (req_i[k]) begin
        gnt_idx_o   = k;
        gnt_valid_o = 1'b1;
      end
    end
    if (gnt_valid_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/xdma_irq_scheduler.sv
// Posts one completed-DMA descriptor at a time to the BAR FIFOs and holds the
// next one off until the host clears the user interrupt or a timeout expires.
module xdma_irq_scheduler
  import xdma_pkg::*;
#(
  parameter int          P_REQ_NUM = 4,
  parameter logic [31:0] P_TIMEOUT = 32'd200_000
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [P_REQ_NUM-1:0]        i_req_valid,
  input  logic [ADDR_W*P_REQ_NUM-1:0] i_req_addr,
  input  logic [LEN_W*P_REQ_NUM-1:0]  i_req_len,
  input  logic [ID_W*P_REQ_NUM-1:0]   i_req_id,
  output logic [P_REQ_NUM-1:0]        o_req_ready,
  output logic [ADDR_W-1:0]           o_bar_addr,
  output logic [LEN_W-1:0]            o_bar_len,
  output logic                        o_bar_valid,
  output logic [ID_W-1:0]             o_stream_id,
  output logic                        o_stream_valid,
  output logic                        o_usr_irq_req,
  input  logic                        i_usr_irq_ack,
  input  logic                        i_interrupt_clear,
  output logic                        o_busy,
  output logic                        o_timeout,
  output logic [TO_CNT_W-1:0]         o_timeout_cnt,
  output logic [STATE_W-1:0]          o_dbg_state
);

  localparam int IDX_W = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;

  // Handshake: a stream raises valid with addr/len/id stable and holds them until
  // it sees its one-cycle o_req_ready bit; that cycle is the transfer.
  // o_req_ready is registered from the IDLE-cycle arbitration.

  logic [ADDR_W-1:0] req_addr [P_REQ_NUM];
  logic [LEN_W-1:0]  req_len  [P_REQ_NUM];
  logic [ID_W-1:0]   req_id   [P_REQ_NUM];

  for (genvar g = 0; g < P_REQ_NUM; g++) begin : g_unpack
    assign req_addr[g] = i_req_addr[g*ADDR_W +: ADDR_W];
    assign req_len[g]  = i_req_len[g*LEN_W +: LEN_W];
    assign req_id[g]   = i_req_id[g*ID_W +: ID_W];
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     win_idx_q, win_idx_d;
  logic [P_REQ_NUM-1:0] ready_q, ready_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 clear_seen_q, clear_seen_d;
  logic                 timeout_q, timeout_d;
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;

  logic [P_REQ_NUM-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .P_REQ_NUM (P_REQ_NUM),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req_i       (i_req_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_idx_d    = win_idx_q;
    ready_d      = '0;
    addr_d       = addr_q;
    len_d        = len_q;
    id_d         = id_q;
    timer_d      = timer_q;
    clear_seen_d = clear_seen_q;
    timeout_d    = 1'b0;
    to_cnt_d     = to_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          ready_d   = arb_gnt;
          win_idx_d = arb_idx;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        addr_d   = req_addr[win_idx_q];
        len_d    = req_len[win_idx_q];
        id_d     = req_id[win_idx_q];
        rr_ptr_d = (win_idx_q == IDX_W'(P_REQ_NUM - 1)) ? '0 : win_idx_q + 1'b1;
        state_d  = ST_POST;
      end
      ST_POST: begin
        state_d = ST_IRQ_SET;
      end
      ST_IRQ_SET: begin
        // A clear that beats the assert-ack is remembered so WAIT_CLR exits at once.
        if (i_interrupt_clear) begin
          clear_seen_d = 1'b1;
        end
        if (i_usr_irq_ack) begin
          timer_d = '0;
          state_d = ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        if (clear_seen_q || i_interrupt_clear) begin
          clear_seen_d = 1'b1;
          state_d      = ST_IRQ_DROP;
        end else if (timer_q == P_TIMEOUT - 32'd1) begin
          timeout_d = 1'b1;
          to_cnt_d  = sat_inc(to_cnt_q);
          state_d   = ST_IRQ_DROP;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_IRQ_DROP: begin
        if (i_usr_irq_ack) begin
          clear_seen_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      win_idx_q    <= '0;
      ready_q      <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      timer_q      <= '0;
      clear_seen_q <= 1'b0;
      timeout_q    <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      win_idx_q    <= win_idx_d;
      ready_q      <= ready_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      id_q         <= id_d;
      timer_q      <= timer_d;
      clear_seen_q <= clear_seen_d;
      timeout_q    <= timeout_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // State-decoded so an asynchronous reset drops the interrupt without a clock.
  assign o_usr_irq_req  = (state_q == ST_IRQ_SET) || (state_q == ST_WAIT_CLR);
  assign o_bar_valid    = (state_q == ST_POST);
  assign o_stream_valid = (state_q == ST_POST);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_req_ready    = ready_q;
  assign o_bar_addr     = addr_q;
  assign o_bar_len      = len_q;
  assign o_stream_id    = id_q;
  assign o_timeout      = timeout_q;
  assign o_timeout_cnt  = to_cnt_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_xdma_irq_scheduler.sv
// Randomized transaction bench for xdma_irq_scheduler with a descriptor-level reference model.
module tb_xdma_irq_scheduler;

  localparam int          N   = 4;
  localparam logic [31:0] TMO = 32'd16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_addr;
  logic [32*N-1:0] req_len;
  logic [8*N-1:0]  req_id;
  logic [N-1:0]    o_req_ready;
  logic [31:0]     o_bar_addr;
  logic [31:0]     o_bar_len;
  logic            o_bar_valid;
  logic [7:0]      o_stream_id;
  logic            o_stream_valid;
  logic            o_usr_irq_req;
  logic            usr_ack;
  logic            int_clr;
  logic            o_busy;
  logic            o_timeout;
  logic [15:0]     o_timeout_cnt;
  logic [2:0]      dbg_state;

  logic [31:0] s_addr [N];
  logic [31:0] s_len  [N];
  logic [7:0]  s_id   [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*32 +: 32] = s_addr[g];
    assign req_len[g*32 +: 32]  = s_len[g];
    assign req_id[g*8 +: 8]     = s_id[g];
  end

  xdma_irq_scheduler #(
    .P_REQ_NUM (N),
    .P_TIMEOUT (TMO)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_req_valid       (req_valid),
    .i_req_addr        (req_addr),
    .i_req_len         (req_len),
    .i_req_id          (req_id),
    .o_req_ready       (o_req_ready),
    .o_bar_addr        (o_bar_addr),
    .o_bar_len         (o_bar_len),
    .o_bar_valid       (o_bar_valid),
    .o_stream_id       (o_stream_id),
    .o_stream_valid    (o_stream_valid),
    .o_usr_irq_req     (o_usr_irq_req),
    .i_usr_irq_ack     (usr_ack),
    .i_interrupt_clear (int_clr),
    .o_busy            (o_busy),
    .o_timeout         (o_timeout),
    .o_timeout_cnt     (o_timeout_cnt),
    .o_dbg_state       (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_rr     = 0;
  logic [15:0] m_tocnt  = '0;
  logic [71:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int ptr);
    for (int d = 0; d < N; d++) begin
      if (m[(ptr + d) % N]) return (ptr + d) % N;
    end
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    usr_ack = 1'b0;
    int_clr = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load_stream(input int k);
    s_addr[k]    = $urandom;
    s_len[k]     = $urandom_range(1, 4096);
    s_id[k]      = 8'($urandom_range(0, 255));
    req_valid[k] = 1'b1;
  endtask

  task automatic refill(input logic [N-1:0] fill);
    for (int k = 0; k < N; k++) begin
      if (fill[k] && !req_valid[k]) load_stream(k);
    end
    if (req_valid == '0) load_stream(int'($urandom_range(0, N - 1)));
  endtask

  // mode: 0 clear before/with assert-ack, 1 clear in WAIT_CLR cycle wait_k,
  //       2 no clear (timeout), 3 async reset in WAIT_CLR cycle wait_k.
  // Entered and left in the IDLE cycle, just after a rising edge.
  task automatic run_txn(input int mode, input int wait_k, input int ack_dly, input int drop_dly,
                         input bit clr_post, input bit clr_drop, input logic [N-1:0] fill);
    int          w;
    int          n_wait;
    int          clr_at;
    logic [N-1:0] seen;
    logic [71:0] e;
    refill(fill);
    mid();
    check("idle_busy", o_busy, 0);
    check("idle_ready", o_req_ready, 0);
    check("idle_irq", o_usr_irq_req, 0);
    check("idle_tocnt", o_timeout_cnt, m_tocnt);
    w = rr_pick(req_valid, m_rr);
    tick();
    // GRANT
    mid();
    check("grant_onehot", o_req_ready, 32'd1 << w);
    check("grant_busy", o_busy, 1);
    check("grant_bar", o_bar_valid, 0);
    seen = o_req_ready;
    exp_q.push_back({s_addr[w], s_len[w], s_id[w]});
    m_rr = (w + 1) % N;
    tick();
    req_valid = req_valid & ~seen;
    if (clr_post) int_clr = 1'b1;
    // POST
    mid();
    check("bar_valid", o_bar_valid, 1);
    check("stream_valid", o_stream_valid, 1);
    check("post_ready", o_req_ready, 0);
    check("post_irq", o_usr_irq_req, 0);
    e = exp_q.pop_front();
    check("bar_addr", o_bar_addr, e[71:40]);
    check("bar_len", o_bar_len, e[39:8]);
    check("stream_id", o_stream_id, {24'd0, e[7:0]});
    tick();
    // IRQ_SET
    if (mode == 0) clr_at = int'($urandom_range(0, ack_dly));
    else clr_at = -1;
    for (int i = 0; i <= ack_dly; i++) begin
      if (i == ack_dly) usr_ack = 1'b1;
      if (i == clr_at) int_clr = 1'b1;
      mid();
      check("set_irq", o_usr_irq_req, 1);
      check("set_bar", o_bar_valid, 0);
      tick();
    end
    // WAIT_CLR
    if (mode == 0) n_wait = 1;
    else if (mode == 1) n_wait = wait_k + 1;
    else n_wait = int'(TMO);
    for (int i = 0; i < n_wait; i++) begin
      if (mode == 3 && i == wait_k) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_irq", o_usr_irq_req, 0);
        check("rst_busy", o_busy, 0);
        check("rst_tocnt", o_timeout_cnt, 0);
        m_rr    = 0;
        m_tocnt = '0;
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      if (mode == 1 && i == wait_k) int_clr = 1'b1;
      if (i == 0 && $urandom_range(0, 1) == 1) usr_ack = 1'b1;
      mid();
      check("wait_irq", o_usr_irq_req, 1);
      check("wait_tmo", o_timeout, 0);
      tick();
    end
    // IRQ_DROP
    if (mode == 2) m_tocnt = (m_tocnt == 16'hFFFF) ? m_tocnt : m_tocnt + 16'd1;
    for (int i = 0; i <= drop_dly; i++) begin
      if (i == drop_dly) usr_ack = 1'b1;
      if (i == 0 && clr_drop) int_clr = 1'b1;
      mid();
      check("drop_irq", o_usr_irq_req, 0);
      check("drop_busy", o_busy, 1);
      check("drop_tmo", o_timeout, (i == 0 && mode == 2) ? 1 : 0);
      if (i == 0) check("drop_tocnt", o_timeout_cnt, m_tocnt);
      tick();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mode;
    int wk;
    rst_n     = 1'b0;
    usr_ack   = 1'b0;
    int_clr   = 1'b0;
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      s_addr[k] = '0;
      s_len[k]  = '0;
      s_id[k]   = '0;
    end
    @(posedge clk);
    #1;
    mid();
    check("rst_ready", o_req_ready, 0);
    check("rst_bar_valid", o_bar_valid, 0);
    check("rst_stream_valid", o_stream_valid, 0);
    check("rst_bar_addr", o_bar_addr, 0);
    check("rst_bar_len", o_bar_len, 0);
    check("rst_stream_id", o_stream_id, 0);
    check("rst_irq0", o_usr_irq_req, 0);
    check("rst_busy0", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_tocnt0", o_timeout_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    s_addr[2]    = 32'h1000_0000;
    s_len[2]     = 32'h0000_0400;
    s_id[2]      = 8'h05;
    req_valid[2] = 1'b1;
    run_txn(1, 2, 1, 1, 1'b0, 1'b0, 4'h0);
    run_txn(3, 5, 0, 0, 1'b0, 1'b0, 4'hF);
    repeat (5) run_txn(1, 0, 0, 0, 1'b0, 1'b0, 4'hF);
    run_txn(0, 0, 0, 0, 1'b0, 1'b0, 4'h0);
    run_txn(0, 0, 3, 1, 1'b0, 1'b0, 4'h0);
    run_txn(2, 0, 1, 2, 1'b0, 1'b0, 4'h0);
    run_txn(1, int'(TMO) - 1, 0, 0, 1'b0, 1'b0, 4'h0);
    run_txn(2, 0, 0, 0, 1'b1, 1'b1, 4'h0);
    run_txn(2, 0, 0, 0, 1'b0, 1'b0, 4'h0);

    repeat (40) begin
      if ($urandom_range(0, 9) == 0) mode = 3;
      else mode = int'($urandom_range(0, 2));
      if (mode == 3) wk = int'($urandom_range(0, TMO - 2));
      else wk = int'($urandom_range(0, TMO - 1));
      run_txn(mode, wk, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/xdma_irq_scheduler.md
# xdma_irq_scheduler

Per-stream write-completion scheduler in front of the BAR register block. It arbitrates completed-DMA descriptors (address, length, stream ID) from up to P_REQ_NUM stream engines and posts one descriptor at a time into the BAR FIFOs. It raises the XDMA user interrupt and holds off the next descriptor until the host writes interrupt-clear or a timeout expires. It sits in the 200 MHz user domain, between the stream DMA engines and the BAR write controller.

## Interface
- P_REQ_NUM, 4, number of requesting stream engines (2..8)
- P_TIMEOUT, 32'd200_000, cycles to wait for host interrupt-clear before forcing release
- i_clk  in  1  200 MHz user clock; one clock domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  P_REQ_NUM  per-stream descriptor valid; held until ready
- i_req_addr  in  32*P_REQ_NUM  descriptor write address; stream k at [32k+31:32k]
- i_req_len  in  32*P_REQ_NUM  descriptor byte length
- i_req_id  in  8*P_REQ_NUM  stream ID
- o_req_ready  out  P_REQ_NUM  one-hot grant pulse; transfer when valid & ready
- o_bar_addr  out  32  to BAR block address FIFO
- o_bar_len  out  32  to BAR block length FIFO
- o_bar_valid  out  1  single-cycle write strobe for addr/len
- o_stream_id  out  8  to BAR block stream-ID FIFO
- o_stream_valid  out  1  single-cycle write strobe, coincident with o_bar_valid
- o_usr_irq_req  out  1  XDMA user interrupt request level
- i_usr_irq_ack  in  1  XDMA ack pulse; once on assert, once on deassert
- i_interrupt_clear  in  1  pulse from BAR block when host writes 1 to the clear register
- o_busy  out  1  high in every state except IDLE
- o_timeout  out  1  single-cycle pulse when P_TIMEOUT expires
- o_timeout_cnt  out  16  saturating count of timeouts

## Operation
- FSM states: IDLE, GRANT, POST, IRQ_SET, WAIT_CLR, IRQ_DROP.
- IDLE: if any i_req_valid is set, go to GRANT.
- GRANT: round-robin pick starting at pointer rr_ptr. Assert o_req_ready for the winner for one cycle and latch its addr/len/id. Set rr_ptr = winner+1 (wrap to 0 after P_REQ_NUM-1). Go to POST.
- POST: drive latched fields; o_bar_valid = o_stream_valid = 1 for exactly one cycle. Go to IRQ_SET.
- IRQ_SET: o_usr_irq_req = 1. On i_usr_irq_ack, go to WAIT_CLR.
- WAIT_CLR: o_usr_irq_req stays 1 and a timer counts up. On clear_seen or i_interrupt_clear, go to IRQ_DROP.
  - On timer == P_TIMEOUT-1 instead: pulse o_timeout, increment o_timeout_cnt (saturate at 16'hFFFF), go to IRQ_DROP.
- IRQ_DROP: o_usr_irq_req = 0. On i_usr_irq_ack, clear clear_seen and go to IDLE.
- clear_seen: sticky flag set by i_interrupt_clear in IRQ_SET or WAIT_CLR. A clear arriving before the assert-ack is not lost. i_interrupt_clear in IDLE, GRANT, POST or IRQ_DROP is ignored.
- An ack outside IRQ_SET/IRQ_DROP is ignored. At most one descriptor is outstanding at any time.

## Timing
- Reset values: all outputs 0, rr_ptr = 0, timer 0, clear_seen 0, state IDLE.
- Reset mid-operation drops o_usr_irq_req immediately. The in-flight descriptor is discarded; it was already consumed if past GRANT.
- Valid to grant: valid sampled in IDLE, o_req_ready in the next cycle (GRANT), o_bar_valid in the cycle after that. Minimum descriptor cycle: 6 clocks plus ack/clear waits.
- o_req_ready is registered and never asserted for a stream whose valid is low in GRANT. Requesters must hold valid and data stable until granted.
- Simultaneous events:
  - clear and timeout expiry in the same cycle: clear wins, no timeout pulse.
  - ack and clear in the same IRQ_SET cycle: both take effect, and WAIT_CLR exits on its first cycle.
- The timer is 32 bits, clears on entering WAIT_CLR, and never wraps.

## Structure
- Shared package xdma_pkg holds: the state encoding (localparam, 3 bit), descriptor field widths (ADDR_W = 32, LEN_W = 32, ID_W = 8), and the timeout counter width.
- One sub-module: rr_arbiter (P_REQ_NUM requests, rr_ptr input, one-hot grant and grant index outputs; combinational). The FSM and latches stay in the top module.

## Test plan
- Single request: stream 2 valid with addr 0x1000_0000, len 0x400, id 0x05 -> o_req_ready = 4'b0100 one cycle, then o_bar_valid with those values, then o_usr_irq_req = 1. Ack, clear, ack -> back to IDLE with o_busy = 0.
- Round robin: all 4 streams valid continuously -> grant order 0, 1, 2, 3, 0. Exactly one o_bar_valid per completed handshake.
- Early clear: i_interrupt_clear pulsed in IRQ_SET before ack -> after the ack, WAIT_CLR lasts 1 cycle and there is no timeout.
- Timeout: P_TIMEOUT = 16, no clear -> o_timeout pulses 16 cycles after entering WAIT_CLR, o_timeout_cnt = 1, then o_usr_irq_req drops.
- Clear/timeout collision: clear on the expiry cycle -> o_timeout stays 0 and o_timeout_cnt is unchanged.
- Async reset asserted in WAIT_CLR -> o_usr_irq_req = 0 without a clock edge. After release, a pending request is re-granted starting from stream 0.
